// File: rtl/ctc_word_timing.sv
// rtl/ctc_word_timing.sv - word-frame timing, instruction fetch, pointer and carry latch ahead of ARC
//
// Purpose: generates the 56-bit-time word frame (start, sync, serial
// instruction is, word-select ws) for the ARC arithmetic block. It fetches one
// instruction per word, executes it in the following word, holds pointer P and
// latches ARC's end-of-word carry.
//
// Ports:
//   cph2        in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   inst_req    out  one-cycle request for the next instruction (T43)
//   inst_in     in   10-bit instruction word
//   inst_vld    in   inst_in valid, only honoured at T44
//   carry       in   ARC carry, sampled at T55 of arithmetic words
//   sync        out  instruction-time marker, T45..T54
//   is          out  serial instruction bit, LSB first during sync
//   ws          out  registered word-select
//   start       out  high during T0
//   carry_flag  out  carry of the last executed arithmetic word
//   ptr         out  pointer register P
module ctc_word_timing #(
  parameter int          WORD_LEN = 56,
  parameter logic [9:0]  NOP_INST = 10'h000
) (
  input  logic       cph2,
  input  logic       rst,
  output logic       inst_req,
  input  logic [9:0] inst_in,
  input  logic       inst_vld,
  input  logic       carry,
  output logic       sync,
  output logic       is,
  output logic       ws,
  output logic       start,
  output logic       carry_flag,
  output logic [3:0] ptr
);

  // Frame landmarks, anchored to the end of the word.
  localparam logic [5:0] T_LAST    = 6'(WORD_LEN - 1);
  localparam logic [5:0] T_REQ     = 6'(WORD_LEN - 13);
  localparam logic [5:0] T_SAMPLE  = 6'(WORD_LEN - 12);
  localparam logic [5:0] T_SYNC_LO = 6'(WORD_LEN - 11);
  localparam logic [5:0] T_SYNC_HI = 6'(WORD_LEN - 2);

  localparam logic [1:0] TYPE_MISC  = 2'b00;
  localparam logic [1:0] TYPE_PTR   = 2'b01;
  localparam logic [1:0] TYPE_ARITH = 2'b10;

  logic [5:0] t_q, t_d;
  logic [9:0] fetch_q, fetch_d;
  // Only the fields the executing word needs are kept: type, field and n.
  logic [1:0] exec_type_q, exec_type_d;
  logic [2:0] exec_field_q, exec_field_d;
  logic [3:0] exec_n_q, exec_n_d;
  logic [3:0] p_q, p_d;
  logic       cf_q, cf_d;
  logic       ws_q, ws_d;
  logic [5:0] is_idx;

  // Word-select for digit d of a word executing (type, field) with pointer p.
  function automatic logic ws_decode(input logic [1:0] typ, input logic [2:0] fld,
                                     input logic [3:0] p, input logic [3:0] d);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = 4'd0;
    hi = 4'd0;
    case (fld)
      3'b000:  begin lo = p;     hi = p;     end
      3'b001:  begin lo = 4'd3;  hi = 4'd12; end
      3'b010:  begin lo = 4'd0;  hi = 4'd1;  end
      3'b011:  begin lo = 4'd0;  hi = 4'd13; end
      3'b100:  begin lo = 4'd3;  hi = 4'd13; end
      3'b101:  begin lo = 4'd2;  hi = 4'd2;  end
      3'b110:  begin lo = 4'd13; hi = 4'd13; end
      default: begin lo = 4'd0;  hi = p;     end
    endcase
    if (typ == TYPE_MISC) begin
      ws_decode = 1'b1;
    end else if (typ == TYPE_ARITH) begin
      ws_decode = (d >= lo) && (d <= hi);
    end else begin
      ws_decode = 1'b0;
    end
  endfunction

  always_comb begin
    t_d          = (t_q == T_LAST) ? 6'd0 : t_q + 6'd1;
    fetch_d      = fetch_q;
    exec_type_d  = exec_type_q;
    exec_field_d = exec_field_q;
    exec_n_d     = exec_n_q;
    p_d          = p_q;
    cf_d         = cf_q;

    // A word arriving late is dropped in favour of a no-op.
    if (t_q == T_SAMPLE) begin
      fetch_d = inst_vld ? inst_in : NOP_INST;
    end

    // End of word: retire the executing word and promote the fetched one.
    if (t_q == T_LAST) begin
      if (exec_type_q == TYPE_PTR && exec_n_q <= 4'd13) begin
        p_d = exec_n_q;
      end
      if (exec_type_q == TYPE_ARITH) begin
        cf_d = carry;
      end
      exec_type_d  = fetch_q[1:0];
      exec_field_d = fetch_q[4:2];
      exec_n_d     = fetch_q[9:6];
    end

    // Decoded from next-state values so the registered ws lines up with t
    // and a new word already sees the updated pointer.
    ws_d = ws_decode(exec_type_d, exec_field_d, p_d, t_d[5:2]);
  end

  always_ff @(posedge cph2 or posedge rst) begin
    if (rst) begin
      t_q          <= 6'd0;
      fetch_q      <= NOP_INST;
      exec_type_q  <= NOP_INST[1:0];
      exec_field_q <= NOP_INST[4:2];
      exec_n_q     <= NOP_INST[9:6];
      p_q          <= 4'd0;
      cf_q         <= 1'b0;
      ws_q         <= 1'b0;
    end else begin
      t_q          <= t_d;
      fetch_q      <= fetch_d;
      exec_type_q  <= exec_type_d;
      exec_field_q <= exec_field_d;
      exec_n_q     <= exec_n_d;
      p_q          <= p_d;
      cf_q         <= cf_d;
      ws_q         <= ws_d;
    end
  end

  assign is_idx     = t_q - T_SYNC_LO;
  assign start      = (t_q == 6'd0);
  assign sync       = (t_q >= T_SYNC_LO) && (t_q <= T_SYNC_HI);
  assign inst_req   = (t_q == T_REQ);
  assign is         = sync ? fetch_q[is_idx[3:0]] : 1'b0;
  assign ws         = ws_q;
  assign carry_flag = cf_q;
  assign ptr        = p_q;

endmodule

// File: tb/tb_ctc_word_timing.sv
// tb/tb_ctc_word_timing.sv - self-checking bench for ctc_word_timing
module tb_ctc_word_timing;

  localparam logic [9:0] NOP = 10'h000;

  logic       cph2 = 1'b0;
  logic       rst = 1'b1;
  logic       inst_req;
  logic [9:0] inst_in = 10'h000;
  logic       inst_vld = 1'b0;
  logic       carry = 1'b0;
  logic       sync;
  logic       is_w;
  logic       ws;
  logic       start;
  logic       carry_flag;
  logic [3:0] ptr;

  int n_tests = 0;
  int n_fail = 0;

  // Behavioural model state.
  int         m_t = 0;
  logic [9:0] m_fetch = NOP;
  logic [9:0] m_exec = NOP;
  int         m_p = 0;
  logic       m_cf = 1'b0;
  logic       m_ws_zero = 1'b1;

  // Per-word traces indexed by bit time.
  logic [55:0] ws_tr, is_tr, sync_tr, req_tr, start_tr;
  logic [3:0]  ptr0;
  logic        cf0;

  ctc_word_timing dut (
    .cph2(cph2), .rst(rst), .inst_req(inst_req), .inst_in(inst_in),
    .inst_vld(inst_vld), .carry(carry), .sync(sync), .is(is_w), .ws(ws),
    .start(start), .carry_flag(carry_flag), .ptr(ptr)
  );

  always #5 cph2 = ~cph2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  function automatic logic ws_model(input logic [9:0] w, input int p, input int t);
    int d;
    int lo;
    int hi;
    d = t / 4;
    lo = 0;
    hi = 0;
    if (w[1:0] == 2'b00) return 1'b1;
    if (w[1:0] != 2'b10) return 1'b0;
    case (w[4:2])
      3'd0: begin lo = p;  hi = p;  end
      3'd1: begin lo = 3;  hi = 12; end
      3'd2: begin lo = 0;  hi = 1;  end
      3'd3: begin lo = 0;  hi = 13; end
      3'd4: begin lo = 3;  hi = 13; end
      3'd5: begin lo = 2;  hi = 2;  end
      3'd6: begin lo = 13; hi = 13; end
      default: begin lo = 0; hi = p; end
    endcase
    return (d >= lo) && (d <= hi);
  endfunction

  always @(posedge cph2 or posedge rst) begin
    if (rst) begin
      m_t = 0; m_fetch = NOP; m_exec = NOP; m_p = 0; m_cf = 1'b0; m_ws_zero = 1'b1;
    end else begin
      m_ws_zero = 1'b0;
      if (m_t == 44) m_fetch = inst_vld ? inst_in : NOP;
      if (m_t == 55) begin
        if (m_exec[1:0] == 2'b01 && int'(m_exec[9:6]) <= 13) m_p = int'(m_exec[9:6]);
        if (m_exec[1:0] == 2'b10) m_cf = carry;
        m_exec = m_fetch;
      end
      m_t = (m_t + 1) % 56;
    end
  end

  always @(negedge cph2) begin
    if (!rst) begin
      check("start", start, m_t == 0);
      check("sync", sync, m_t >= 45 && m_t <= 54);
      check("inst_req", inst_req, m_t == 43);
      check("is", is_w, (m_t >= 45 && m_t <= 54) ? m_fetch[m_t-45] : 1'b0);
      check("ws", ws, m_ws_zero ? 1'b0 : ws_model(m_exec, m_p, m_t));
      check("carry_flag", carry_flag, m_cf);
      check("ptr", ptr, m_p[3:0]);
    end
  end

  // Runs one word from T0 (caller is at a negedge with t==0) through T55.
  task automatic do_word(input logic [9:0] inst, input logic vld, input logic c55, input logic noise);
    ws_tr = '0; is_tr = '0; sync_tr = '0; req_tr = '0; start_tr = '0;
    forever begin
      ws_tr[m_t] = ws; is_tr[m_t] = is_w; sync_tr[m_t] = sync;
      req_tr[m_t] = inst_req; start_tr[m_t] = start;
      if (m_t == 0) begin ptr0 = ptr; cf0 = carry_flag; end
      if (m_t == 44) begin
        inst_in = inst; inst_vld = vld;
      end else begin
        inst_in = 10'($urandom); inst_vld = noise ? 1'($urandom) : 1'b0;
      end
      carry = (m_t == 55) ? c55 : 1'($urandom);
      if (m_t == 55) break;
      @(negedge cph2);
    end
    @(negedge cph2);
  endtask

  initial begin
    repeat (3) @(negedge cph2);
    #1 rst = 1'b0;

    // W0: no valid instruction ever
    do_word(10'h3FF, 1'b0, 1'b0, 1'b0);
    check("w0_start", start_tr, 56'h00000000000001);
    check("w0_sync", sync_tr, 56'h7FE00000000000);
    check("w0_req", req_tr, 56'h00080000000000);
    check("w0_is", is_tr, 56'h0);
    // W1: fetch W-field arith
    do_word(10'b1110101110, 1'b1, 1'b0, 1'b1);
    check("w1_is_bits", is_tr[54:45], 10'b1110101110);
    // W2: executes W, fetch P=5
    do_word(10'b0101000001, 1'b1, 1'b0, 1'b1);
    check("w2_ws_all", ws_tr, {56{1'b1}});
    // W3: executes P=5, fetch arith field P
    do_word(10'b1010100010, 1'b1, 1'b0, 1'b1);
    check("w3_ws_none", ws_tr, 56'h0);
    // W4: executes arith P, fetch WP; carry 1 at T55
    do_word(10'b0110011110, 1'b1, 1'b1, 1'b1);
    check("w4_ptr", ptr0, 4'd5);
    check("w4_ws_p", ws_tr, 56'h00000000F00000);
    // W5: executes WP, fetch misc
    do_word(10'b0000011100, 1'b1, 1'b1, 1'b1);
    check("w5_ws_wp", ws_tr, 56'h00000000FFFFFF);
    check("w5_cf", cf0, 1'b1);
    // W6: executes misc with carry 0, fetch P=14
    do_word(10'b1110000001, 1'b1, 1'b0, 1'b1);
    check("w6_ws_misc", ws_tr, {56{1'b1}});
    // W7: executes P=14, fetch arith X
    do_word(10'b0011101010, 1'b1, 1'b0, 1'b1);
    check("w7_cf_hold", cf0, 1'b1);
    // W8: executes X, fetch W arith; carry 1
    do_word(10'b1110101110, 1'b1, 1'b1, 1'b1);
    check("w8_ptr_hold", ptr0, 4'd5);
    check("w8_ws_x", ws_tr, 56'h000000000000FF);

    // W9: arith W executing, reset asserted at T30
    forever begin
      inst_in = 10'($urandom); inst_vld = 1'($urandom); carry = 1'($urandom);
      if (m_t == 30) break;
      @(negedge cph2);
    end
    check("pre_rst_ws", ws, 1'b1);
    check("pre_rst_cf", carry_flag, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_ws", ws, 1'b0);
    check("rst_ptr", ptr, 4'd0);
    check("rst_cf", carry_flag, 1'b0);
    check("rst_start", start, 1'b1);
    check("rst_sync", sync, 1'b0);
    check("rst_is", is_w, 1'b0);
    check("rst_req", inst_req, 1'b0);
    repeat (2) @(negedge cph2);
    #1 rst = 1'b0;

    do_word(10'b1110101110, 1'b1, 1'b0, 1'b1);
    check("post_rst_ws0", ws_tr[0], 1'b0);
    check("post_rst_ptr", ptr0, 4'd0);
    check("post_rst_cf", cf0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      do_word(10'($urandom), ($urandom % 4) != 0, 1'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctc_word_timing.md
Name: ctc_word_timing

Overview:
- Upstream control-and-timing stage for the ARC arithmetic block.
- Generates the 56-bit-time word frame: sync, serial instruction stream is, and word-select ws.
- Fetches 10-bit instruction words through a request/valid handshake and holds the pointer register P.
- Latches the carry produced by ARC at end of word for branch logic.

Parameters:
- WORD_LEN, 56, bit times per word (14 BCD digits x 4).
- NOP_INST, 10'h000, instruction substituted when fetch data is late.

Ports:
- cph2 input 1: system clock; all state on rising edge.
- rst input 1: asynchronous, active-high reset.
- inst_req output 1: one-cycle pulse requesting the next instruction.
- inst_in input 10: instruction word. Bits [1:0] are the type, [4:2] the field, [9:5] the opcode; for type 01, [9:6] is n.
- inst_vld input 1: inst_in valid; accepted only when high in the cycle after inst_req.
- carry input 1: carry output of ARC.
- sync output 1: instruction-time frame marker to ARC.
- is output 1: serial instruction bit to ARC.
- ws output 1: word-select to ARC.
- start output 1: high during T0.
- carry_flag output 1: carry latched for the last executed word.
- ptr output 4: current pointer P.

Behaviour:
- Bit counter t counts 0..WORD_LEN-1 and wraps 55→0. Reset sets t=0.
- start = (t==0). sync = (t in 45..54).
- inst_req pulses at t==43. inst_vld is sampled at t==44:
  - high: fetch_r <= inst_in;
  - low: fetch_r <= NOP_INST (late word dropped; inst_vld outside t==44 ignored).
- is = fetch_r[t-45] for t in 45..54, LSB first, so type bits are at T45–T46 and opcode bits at T50–T54. is=0 at all other times.
- At t==55: exec_r <= fetch_r. The fetched word executes in the following word, matching ARC's latch point.
- ws, from exec_r, per digit d = t>>2 (digit d occupies t=4d..4d+3):
  - type 10 (arith): field 000 P: d==P. 001 M: 3..12. 010 X: 0..1. 011 W: 0..13. 100 MS: 3..13. 101 XS: 2. 110 S: 13. 111 WP: 0..P.
  - type 00 (misc): ws high t=0..55.
  - types 01 and 11: ws=0.
- ws is registered: a glitch-free level for the whole digit, aligned to the same cycle as t.
- Pointer update: if exec_r type==01, at t==55 of the execution word P <= n when n<=13; n>13 leaves P unchanged. New P governs ws from the next word on.
- Carry latch:
  - carry_flag is updated at t==55 of each word with type 10 executing: carry_flag <= carry sampled that cycle. Otherwise it holds.
  - carry_flag is updated in the same edge that loads the new exec_r.
- Simultaneous events: a P-field arith instruction executing in the word where a P=n also executes is impossible (one exec per word). P change and exec_r load share the T55 edge; the new exec_r sees the new P.
- Reset values, applied asynchronously (including mid-word): t=0, fetch_r=exec_r=NOP_INST, P=0, carry_flag=0, sync=0, is=0, ws=0, start=1 after release, inst_req=0.
  - First fetch occurs in the first word after reset.
  - ws stays 0 for the first two words unless NOP_INST is type 00 (default is type 00 misc → ws high whole word; ARC treats misc 00000 as no-op).

Test Plan:
- Reset release, inst_vld never asserted → start high at T0 every 56 cycles; sync high exactly T45–T54; is all zero; inst_req at T43 each word.
- Present 10'b1110101110 (opcode 11101, field 011 W, type 10) at T44 → is sequence 0,1,1,1,0,1,0,1,1,1 over T45–T54; next word ws high T0–T55.
- Execute P=5 (inst_in 10'b0101000001), then field 000 arith → ptr=5 after T55; the following arith word has ws high only T20–T23. With field 111 WP, ws is high T0–T23.
- P=14 (n=4'b1110) → ptr holds previous value; field X arith → ws high T0–T7.
- Arith instruction executing with carry=1 at T55 → carry_flag=1. Next word type 00 with carry=0 → carry_flag stays 1.
- Assert rst at T30 with an arith instruction in exec_r → all outputs clear immediately. After release, t restarts at 0 and ws=0 until a fetched instruction executes.
